// File: rtl/aludec_hs_pkg.sv
// Shared MIPS decode constants for the aludec_hs stage.
// - Opcodes: primary op field values.
// - Funct codes: R-type funct field values.
// - REGIMM rt and COP0 rs field codes.
// - Internal aluop codes (EXE_*_OP). They are 8 bits wide and are
//   zero-extended to OP_W by the top module.
// - hilo_kind_e: how an instruction uses HI/LO, tracked in the E register.
package aludec_hs_pkg;

  typedef logic [7:0] alu_op_t;

  // Primary opcodes
  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_REGIMM  = 6'b000001;
  localparam logic [5:0] EXE_J       = 6'b000010;
  localparam logic [5:0] EXE_JAL     = 6'b000011;
  localparam logic [5:0] EXE_BEQ     = 6'b000100;
  localparam logic [5:0] EXE_BNE     = 6'b000101;
  localparam logic [5:0] EXE_BLEZ    = 6'b000110;
  localparam logic [5:0] EXE_BGTZ    = 6'b000111;
  localparam logic [5:0] EXE_ADDI    = 6'b001000;
  localparam logic [5:0] EXE_ADDIU   = 6'b001001;
  localparam logic [5:0] EXE_SLTI    = 6'b001010;
  localparam logic [5:0] EXE_SLTIU   = 6'b001011;
  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_XORI    = 6'b001110;
  localparam logic [5:0] EXE_LUI     = 6'b001111;
  localparam logic [5:0] EXE_COP0    = 6'b010000;
  localparam logic [5:0] EXE_LB      = 6'b100000;
  localparam logic [5:0] EXE_LH      = 6'b100001;
  localparam logic [5:0] EXE_LW      = 6'b100011;
  localparam logic [5:0] EXE_LBU     = 6'b100100;
  localparam logic [5:0] EXE_LHU     = 6'b100101;
  localparam logic [5:0] EXE_SB      = 6'b101000;
  localparam logic [5:0] EXE_SH      = 6'b101001;
  localparam logic [5:0] EXE_SW      = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] EXE_SLL     = 6'b000000;
  localparam logic [5:0] EXE_SRL     = 6'b000010;
  localparam logic [5:0] EXE_SRA     = 6'b000011;
  localparam logic [5:0] EXE_SLLV    = 6'b000100;
  localparam logic [5:0] EXE_SRLV    = 6'b000110;
  localparam logic [5:0] EXE_SRAV    = 6'b000111;
  localparam logic [5:0] EXE_JR      = 6'b001000;
  localparam logic [5:0] EXE_JALR    = 6'b001001;
  localparam logic [5:0] EXE_SYSCALL = 6'b001100;
  localparam logic [5:0] EXE_BREAK   = 6'b001101;
  localparam logic [5:0] EXE_MFHI    = 6'b010000;
  localparam logic [5:0] EXE_MTHI    = 6'b010001;
  localparam logic [5:0] EXE_MFLO    = 6'b010010;
  localparam logic [5:0] EXE_MTLO    = 6'b010011;
  localparam logic [5:0] EXE_MULT    = 6'b011000;
  localparam logic [5:0] EXE_MULTU   = 6'b011001;
  localparam logic [5:0] EXE_DIV     = 6'b011010;
  localparam logic [5:0] EXE_DIVU    = 6'b011011;
  localparam logic [5:0] EXE_ADD     = 6'b100000;
  localparam logic [5:0] EXE_ADDU    = 6'b100001;
  localparam logic [5:0] EXE_SUB     = 6'b100010;
  localparam logic [5:0] EXE_SUBU    = 6'b100011;
  localparam logic [5:0] EXE_AND     = 6'b100100;
  localparam logic [5:0] EXE_OR      = 6'b100101;
  localparam logic [5:0] EXE_XOR     = 6'b100110;
  localparam logic [5:0] EXE_NOR     = 6'b100111;
  localparam logic [5:0] EXE_SLT     = 6'b101010;
  localparam logic [5:0] EXE_SLTU    = 6'b101011;
  localparam logic [5:0] EXE_ERET    = 6'b011000;  // funct under COP0 CO

  // REGIMM rt and COP0 rs field codes
  localparam logic [4:0] EXE_BLTZ    = 5'b00000;
  localparam logic [4:0] EXE_BGEZ    = 5'b00001;
  localparam logic [4:0] EXE_BLTZAL  = 5'b10000;
  localparam logic [4:0] EXE_BGEZAL  = 5'b10001;
  localparam logic [4:0] EXE_COP0_MF = 5'b00000;
  localparam logic [4:0] EXE_COP0_MT = 5'b00100;
  localparam logic [4:0] EXE_COP0_CO = 5'b10000;

  // aluop codes
  localparam alu_op_t EXE_NOP_OP     = 8'h00;
  localparam alu_op_t EXE_SRL_OP     = 8'h02;
  localparam alu_op_t EXE_SRA_OP     = 8'h03;
  localparam alu_op_t EXE_SLLV_OP    = 8'h04;
  localparam alu_op_t EXE_SRLV_OP    = 8'h06;
  localparam alu_op_t EXE_SRAV_OP    = 8'h07;
  localparam alu_op_t EXE_BREAK_OP   = 8'h0B;
  localparam alu_op_t EXE_SYSCALL_OP = 8'h0C;
  localparam alu_op_t EXE_MFHI_OP    = 8'h10;
  localparam alu_op_t EXE_MTHI_OP    = 8'h11;
  localparam alu_op_t EXE_MFLO_OP    = 8'h12;
  localparam alu_op_t EXE_MTLO_OP    = 8'h13;
  localparam alu_op_t EXE_MULT_OP    = 8'h18;
  localparam alu_op_t EXE_MULTU_OP   = 8'h19;
  localparam alu_op_t EXE_DIV_OP     = 8'h1A;
  localparam alu_op_t EXE_DIVU_OP    = 8'h1B;
  localparam alu_op_t EXE_ADD_OP     = 8'h20;
  localparam alu_op_t EXE_ADDU_OP    = 8'h21;
  localparam alu_op_t EXE_SUB_OP     = 8'h22;
  localparam alu_op_t EXE_SUBU_OP    = 8'h23;
  localparam alu_op_t EXE_AND_OP     = 8'h24;
  localparam alu_op_t EXE_OR_OP      = 8'h25;
  localparam alu_op_t EXE_XOR_OP     = 8'h26;
  localparam alu_op_t EXE_NOR_OP     = 8'h27;
  localparam alu_op_t EXE_SLT_OP     = 8'h2A;
  localparam alu_op_t EXE_SLTU_OP    = 8'h2B;
  localparam alu_op_t EXE_ADDI_OP    = 8'h55;
  localparam alu_op_t EXE_ADDIU_OP   = 8'h56;
  localparam alu_op_t EXE_SLTI_OP    = 8'h57;
  localparam alu_op_t EXE_SLTIU_OP   = 8'h58;
  localparam alu_op_t EXE_ANDI_OP    = 8'h59;
  localparam alu_op_t EXE_ORI_OP     = 8'h5A;
  localparam alu_op_t EXE_XORI_OP    = 8'h5B;
  localparam alu_op_t EXE_LUI_OP     = 8'h5C;
  localparam alu_op_t EXE_MFC0_OP    = 8'h5D;
  localparam alu_op_t EXE_MTC0_OP    = 8'h60;
  localparam alu_op_t EXE_ERET_OP    = 8'h6B;
  localparam alu_op_t EXE_SLL_OP     = 8'h7C;
  localparam alu_op_t EXE_LB_OP      = 8'hE0;
  localparam alu_op_t EXE_LH_OP      = 8'hE1;
  localparam alu_op_t EXE_LW_OP      = 8'hE3;
  localparam alu_op_t EXE_LBU_OP     = 8'hE4;
  localparam alu_op_t EXE_LHU_OP     = 8'hE5;
  localparam alu_op_t EXE_SB_OP      = 8'hE8;
  localparam alu_op_t EXE_SH_OP      = 8'hE9;
  localparam alu_op_t EXE_SW_OP      = 8'hEB;

  // HI/LO usage. Anything other than HlNone writes HI/LO.
  typedef enum logic [1:0] {
    HlNone,  // no HI/LO write (includes MFHI/MFLO)
    HlMul,   // MULT/MULTU
    HlDiv,   // DIV/DIVU
    HlMove   // MTHI/MTLO
  } hilo_kind_e;

endpackage

// File: rtl/aludec_hs_hilo_scoreboard.sv
// HI/LO scoreboard for aludec_hs.
// busy_cnt is loaded with the unit latency when a multiply or divide issues
// from E, and counts down to zero otherwise. A load takes priority over the
// decrement.
// Ports:
//   clk, rst             clock, async active-low reset
//   issue_mul_i          MULT/MULTU leaves E this cycle
//   issue_div_i          DIV/DIVU leaves E this cycle
//   e_holds_writer_i     E register holds a valid HI/LO writer
//   busy_o               HI/LO unavailable (count running or writer in E)
module aludec_hs_hilo_scoreboard #(
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_mul_i,
  input  logic issue_div_i,
  input  logic e_holds_writer_i,
  output logic busy_o
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  logic [CntW-1:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (issue_div_i) begin
      busy_cnt_d = CntW'(DIV_LAT);
    end else if (issue_mul_i) begin
      busy_cnt_d = CntW'(MUL_LAT);
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - CntW'(1);
    end
  end

  // Flush never reaches here: an issued divide runs to completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_o = (busy_cnt_q != '0) | e_holds_writer_i;

endmodule

// File: rtl/aludec_hs.sv
// ALU-operation decode stage with a valid/ready handshake into Execute.
// Decodes op/funct/rs/rt into an aluop plus a reserved-instruction flag and
// registers both into the D->E register. HI/LO-class instructions are held
// in Decode while HI/LO is busy.
// Ports:
//   clk, rst               clock, async active-low reset
//   flush_i                squash the E register content
//   d_valid_i, d_ready_o   Decode-side handshake
//   op_i/funct_i/rs_i/rt_i instruction fields
//   e_valid_o, e_ready_i   Execute-side handshake
//   aluop_o, ri_o          registered aluop and reserved-instruction flag
//   hilo_busy_o            HI/LO unavailable
module aludec_hs
  import aludec_hs_pkg::*;
#(
  parameter int unsigned OP_W      = 8,
  parameter int unsigned MUL_LAT   = 1,
  parameter int unsigned DIV_LAT   = 32,
  parameter bit          EN_MULDIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            d_valid_i,
  output logic            d_ready_o,
  input  logic [5:0]      op_i,
  input  logic [5:0]      funct_i,
  input  logic [4:0]      rs_i,
  input  logic [4:0]      rt_i,
  output logic            e_valid_o,
  input  logic            e_ready_i,
  output logic [OP_W-1:0] aluop_o,
  output logic            ri_o,
  output logic            hilo_busy_o
);

  alu_op_t    dec_aluop;
  logic       dec_ri;
  logic       dec_hilo;
  hilo_kind_e dec_kind;

  always_comb begin
    dec_aluop = EXE_NOP_OP;
    dec_ri    = 1'b0;
    dec_hilo  = 1'b0;
    dec_kind  = HlNone;
    unique case (op_i)
      EXE_SPECIAL: begin
        unique case (funct_i)
          EXE_SLL:     dec_aluop = EXE_SLL_OP;
          EXE_SRL:     dec_aluop = EXE_SRL_OP;
          EXE_SRA:     dec_aluop = EXE_SRA_OP;
          EXE_SLLV:    dec_aluop = EXE_SLLV_OP;
          EXE_SRLV:    dec_aluop = EXE_SRLV_OP;
          EXE_SRAV:    dec_aluop = EXE_SRAV_OP;
          EXE_JR, EXE_JALR: dec_aluop = EXE_NOP_OP;
          EXE_SYSCALL: dec_aluop = EXE_SYSCALL_OP;
          EXE_BREAK:   dec_aluop = EXE_BREAK_OP;
          EXE_MFHI:  begin dec_aluop = EXE_MFHI_OP;  dec_hilo = 1'b1; end
          EXE_MFLO:  begin dec_aluop = EXE_MFLO_OP;  dec_hilo = 1'b1; end
          EXE_MTHI:  begin dec_aluop = EXE_MTHI_OP;  dec_hilo = 1'b1; dec_kind = HlMove; end
          EXE_MTLO:  begin dec_aluop = EXE_MTLO_OP;  dec_hilo = 1'b1; dec_kind = HlMove; end
          EXE_MULT:  begin dec_aluop = EXE_MULT_OP;  dec_hilo = 1'b1; dec_kind = HlMul;  end
          EXE_MULTU: begin dec_aluop = EXE_MULTU_OP; dec_hilo = 1'b1; dec_kind = HlMul;  end
          EXE_DIV:   begin dec_aluop = EXE_DIV_OP;   dec_hilo = 1'b1; dec_kind = HlDiv;  end
          EXE_DIVU:  begin dec_aluop = EXE_DIVU_OP;  dec_hilo = 1'b1; dec_kind = HlDiv;  end
          EXE_ADD:     dec_aluop = EXE_ADD_OP;
          EXE_ADDU:    dec_aluop = EXE_ADDU_OP;
          EXE_SUB:     dec_aluop = EXE_SUB_OP;
          EXE_SUBU:    dec_aluop = EXE_SUBU_OP;
          EXE_AND:     dec_aluop = EXE_AND_OP;
          EXE_OR:      dec_aluop = EXE_OR_OP;
          EXE_XOR:     dec_aluop = EXE_XOR_OP;
          EXE_NOR:     dec_aluop = EXE_NOR_OP;
          EXE_SLT:     dec_aluop = EXE_SLT_OP;
          EXE_SLTU:    dec_aluop = EXE_SLTU_OP;
          default:     dec_ri    = 1'b1;
        endcase
      end
      EXE_REGIMM: begin
        unique case (rt_i)
          EXE_BLTZ, EXE_BGEZ, EXE_BLTZAL, EXE_BGEZAL: dec_aluop = EXE_NOP_OP;
          default: dec_ri = 1'b1;
        endcase
      end
      EXE_J, EXE_JAL, EXE_BEQ, EXE_BNE, EXE_BLEZ, EXE_BGTZ: dec_aluop = EXE_NOP_OP;
      EXE_ADDI:  dec_aluop = EXE_ADDI_OP;
      EXE_ADDIU: dec_aluop = EXE_ADDIU_OP;
      EXE_SLTI:  dec_aluop = EXE_SLTI_OP;
      EXE_SLTIU: dec_aluop = EXE_SLTIU_OP;
      EXE_ANDI:  dec_aluop = EXE_ANDI_OP;
      EXE_ORI:   dec_aluop = EXE_ORI_OP;
      EXE_XORI:  dec_aluop = EXE_XORI_OP;
      EXE_LUI:   dec_aluop = EXE_LUI_OP;
      EXE_LB:    dec_aluop = EXE_LB_OP;
      EXE_LH:    dec_aluop = EXE_LH_OP;
      EXE_LW:    dec_aluop = EXE_LW_OP;
      EXE_LBU:   dec_aluop = EXE_LBU_OP;
      EXE_LHU:   dec_aluop = EXE_LHU_OP;
      EXE_SB:    dec_aluop = EXE_SB_OP;
      EXE_SH:    dec_aluop = EXE_SH_OP;
      EXE_SW:    dec_aluop = EXE_SW_OP;
      EXE_COP0: begin
        if (rs_i == EXE_COP0_MF) begin
          dec_aluop = EXE_MFC0_OP;
        end else if (rs_i == EXE_COP0_MT) begin
          dec_aluop = EXE_MTC0_OP;
        end else if (rs_i == EXE_COP0_CO && funct_i == EXE_ERET) begin
          dec_aluop = EXE_ERET_OP;
        end else begin
          dec_ri = 1'b1;
        end
      end
      default: dec_ri = 1'b1;
    endcase

    // Without a mul/div unit the whole HI/LO class is reserved and never
    // touches the scoreboard.
    if (!EN_MULDIV && dec_hilo) begin
      dec_aluop = EXE_NOP_OP;
      dec_ri    = 1'b1;
      dec_hilo  = 1'b0;
      dec_kind  = HlNone;
    end
  end

  // E register
  logic            e_valid_q, e_valid_d;
  logic [OP_W-1:0] aluop_q, aluop_d;
  logic            ri_q, ri_d;
  hilo_kind_e      e_kind_q, e_kind_d;

  logic sb_busy, hazard, accept, issue;

  // sb_busy already covers both "count running" and "writer in E".
  assign hazard    = dec_hilo & sb_busy;
  assign d_ready_o = (~e_valid_q | e_ready_i) & ~(d_valid_i & hazard);
  assign accept    = d_valid_i & d_ready_o;
  assign issue     = e_valid_q & e_ready_i & ~flush_i;

  always_comb begin
    e_valid_d = e_valid_q;
    aluop_d   = aluop_q;
    ri_d      = ri_q;
    e_kind_d  = e_kind_q;
    if (flush_i) begin
      e_valid_d = 1'b0;
      aluop_d   = '0;
      ri_d      = 1'b0;
      e_kind_d  = HlNone;
    end else if (accept) begin
      e_valid_d = 1'b1;
      aluop_d   = OP_W'(dec_aluop);
      ri_d      = dec_ri;
      e_kind_d  = dec_kind;
    end else if (issue) begin
      e_valid_d = 1'b0;
      aluop_d   = '0;
      ri_d      = 1'b0;
      e_kind_d  = HlNone;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid_q <= 1'b0;
      aluop_q   <= '0;
      ri_q      <= 1'b0;
      e_kind_q  <= HlNone;
    end else begin
      e_valid_q <= e_valid_d;
      aluop_q   <= aluop_d;
      ri_q      <= ri_d;
      e_kind_q  <= e_kind_d;
    end
  end

  aludec_hs_hilo_scoreboard #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_hilo_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .issue_mul_i     (issue & (e_kind_q == HlMul)),
    .issue_div_i     (issue & (e_kind_q == HlDiv)),
    .e_holds_writer_i(e_valid_q & (e_kind_q != HlNone)),
    .busy_o          (sb_busy)
  );

  assign e_valid_o   = e_valid_q;
  assign aluop_o     = aluop_q;
  assign ri_o        = ri_q;
  assign hilo_busy_o = sb_busy;

endmodule

// File: tb/tb_aludec_hs.sv
// Directed bench for aludec_hs: decode table, DIV/MFLO hazard timing,
// back-pressure, flush, async reset mid-divide, and EN_MULDIV=0.
module tb_aludec_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       d_valid = 1'b0;
  logic       e_ready = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic [4:0] rs = '0;
  logic [4:0] rt = '0;

  logic       d_ready, e_valid, ri, hilo_busy;
  logic [7:0] aluop;
  logic       n_d_ready, n_e_valid, n_ri, n_hilo_busy;
  logic [7:0] n_aluop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aludec_hs #(.OP_W(8), .MUL_LAT(1), .DIV_LAT(32), .EN_MULDIV(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush), .d_valid_i(d_valid), .d_ready_o(d_ready),
    .op_i(op), .funct_i(funct), .rs_i(rs), .rt_i(rt), .e_valid_o(e_valid),
    .e_ready_i(e_ready), .aluop_o(aluop), .ri_o(ri), .hilo_busy_o(hilo_busy)
  );

  aludec_hs #(.OP_W(8), .MUL_LAT(1), .DIV_LAT(32), .EN_MULDIV(1'b0)) u_dut_nomd (
    .clk(clk), .rst(rst), .flush_i(flush), .d_valid_i(d_valid), .d_ready_o(n_d_ready),
    .op_i(op), .funct_i(funct), .rs_i(rs), .rt_i(rt), .e_valid_o(n_e_valid),
    .e_ready_i(e_ready), .aluop_o(n_aluop), .ri_o(n_ri), .hilo_busy_o(n_hilo_busy)
  );

  // Decode vectors: op, funct, rs, rt -> expected aluop, ri
  localparam int NVec = 18;
  logic [5:0] v_op    [NVec] = '{6'o15, 6'o77, 6'o00, 6'o04, 6'o00, 6'o00, 6'o43, 6'o53, 6'o17,
                                 6'o20, 6'o20, 6'o20, 6'o20, 6'o20, 6'o01, 6'o01, 6'o00, 6'o00};
  logic [5:0] v_funct [NVec] = '{6'o00, 6'o00, 6'o05, 6'o00, 6'o41, 6'o00, 6'o00, 6'o00, 6'o00,
                                 6'o00, 6'o00, 6'o30, 6'o01, 6'o00, 6'o00, 6'o00, 6'o10, 6'o14};
  logic [4:0] v_rs    [NVec] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                                 5'd0, 5'd4, 5'd16, 5'd16, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [4:0] v_rt    [NVec] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                                 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd17, 5'd2, 5'd0, 5'd0};
  logic [7:0] v_aluop [NVec] = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h21, 8'h7C, 8'hE3, 8'hEB, 8'h5C,
                                 8'h5D, 8'h60, 8'h6B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0C};
  logic       v_ri    [NVec] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] o, input logic [5:0] f);
    d_valid = 1'b1;
    op      = o;
    funct   = f;
    rs      = '0;
    rt      = '0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({e_valid, aluop, ri, hilo_busy} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state: got ev=%b aluop=%h ri=%b busy=%b want all 0",
               e_valid, aluop, ri, hilo_busy);
    end
    step();
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if (d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", d_ready);
    end
  endtask

  task automatic test_decode();
    e_ready = 1'b1;
    for (int i = 0; i < NVec; i++) begin
      d_valid = 1'b1;
      op = v_op[i];
      funct = v_funct[i];
      rs = v_rs[i];
      rt = v_rt[i];
      #1;
      n_checks++;
      if (d_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL decode_ready[%0d]: got %b want 1", i, d_ready);
      end
      step();
      n_checks++;
      if (e_valid !== 1'b1 || aluop !== v_aluop[i] || ri !== v_ri[i]) begin
        n_fail++;
        $display("FAIL decode[%0d]: got ev=%b aluop=%h ri=%b want ev=1 aluop=%h ri=%b",
                 i, e_valid, aluop, ri, v_aluop[i], v_ri[i]);
      end
    end
    d_valid = 1'b0;
    step();
    n_checks++;
    if (e_valid !== 1'b0 || aluop !== 8'h00) begin
      n_fail++;
      $display("FAIL decode_drain: got ev=%b aluop=%h want ev=0 aluop=00", e_valid, aluop);
    end
  endtask

  task automatic test_div_hazard();
    int stalls = 0;
    e_ready = 1'b1;
    present(6'o00, 6'o32);  // DIV
    step();
    n_checks++;
    if (e_valid !== 1'b1 || aluop !== 8'h1A || hilo_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL div_in_e: got ev=%b aluop=%h busy=%b want 1/1a/1", e_valid, aluop, hilo_busy);
    end
    present(6'o00, 6'o22);  // MFLO
    #1;
    while (d_ready !== 1'b1 && stalls < 40) begin
      stalls++;
      step();
      if (stalls == 1) begin
        n_checks++;
        if (e_valid !== 1'b0 || hilo_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL div_counting: got ev=%b busy=%b want ev=0 busy=1", e_valid, hilo_busy);
        end
      end
    end
    n_checks++;
    if (stalls != 33) begin
      n_fail++;
      $display("FAIL div_stall_cycles: got %0d want 33", stalls);
    end
    n_checks++;
    if (hilo_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL div_busy_fall: got %b want 0", hilo_busy);
    end
    step();
    n_checks++;
    if (e_valid !== 1'b1 || aluop !== 8'h12) begin
      n_fail++;
      $display("FAIL mflo_accept: got ev=%b aluop=%h want 1/12", e_valid, aluop);
    end
    d_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    e_ready = 1'b1;
    present(6'o00, 6'o40);  // ADD
    step();
    e_ready = 1'b0;
    present(6'o00, 6'o42);  // SUB
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (d_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got %b want 0", i, d_ready);
      end
      step();
      n_checks++;
      if (e_valid !== 1'b1 || aluop !== 8'h20) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ev=%b aluop=%h want 1/20", i, e_valid, aluop);
      end
    end
    e_ready = 1'b1;
    #1;
    n_checks++;
    if (d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 1", d_ready);
    end
    step();
    n_checks++;
    if (e_valid !== 1'b1 || aluop !== 8'h22) begin
      n_fail++;
      $display("FAIL bp_release_load: got ev=%b aluop=%h want 1/22", e_valid, aluop);
    end
    d_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    e_ready = 1'b1;
    present(6'o00, 6'o32);  // DIV
    step();
    flush = 1'b1;
    present(6'o00, 6'o20);  // MFHI
    step();
    flush = 1'b0;
    #1;
    n_checks++;
    if (e_valid !== 1'b0 || aluop !== 8'h00 || hilo_busy !== 1'b0 || d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_div: got ev=%b aluop=%h busy=%b rdy=%b want 0/00/0/1",
               e_valid, aluop, hilo_busy, d_ready);
    end
    step();
    n_checks++;
    if (e_valid !== 1'b1 || aluop !== 8'h10) begin
      n_fail++;
      $display("FAIL flush_mfhi: got ev=%b aluop=%h want 1/10", e_valid, aluop);
    end
    // Flush discards a concurrent accept.
    flush = 1'b1;
    present(6'o15, 6'o00);  // ORI
    step();
    flush = 1'b0;
    d_valid = 1'b0;
    n_checks++;
    if (e_valid !== 1'b0 || aluop !== 8'h00) begin
      n_fail++;
      $display("FAIL flush_accept: got ev=%b aluop=%h want 0/00", e_valid, aluop);
    end
  endtask

  task automatic test_reset_mid_div();
    e_ready = 1'b1;
    present(6'o00, 6'o33);  // DIVU
    step();
    d_valid = 1'b0;
    step();
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (hilo_busy !== 1'b0 || e_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b ev=%b want 0/0", hilo_busy, e_valid);
    end
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (hilo_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_busy: got %b want 0", hilo_busy);
    end
  endtask

  task automatic test_no_muldiv();
    e_ready = 1'b1;
    present(6'o00, 6'o30);  // MULT
    step();
    d_valid = 1'b0;
    n_checks++;
    if (n_e_valid !== 1'b1 || n_aluop !== 8'h00 || n_ri !== 1'b1 || n_hilo_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nomd_mult: got ev=%b aluop=%h ri=%b busy=%b want 1/00/1/0",
               n_e_valid, n_aluop, n_ri, n_hilo_busy);
    end
    step();
    n_checks++;
    if (n_hilo_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nomd_busy: got %b want 0", n_hilo_busy);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_div_hazard();
    test_backpressure();
    test_flush();
    test_reset_mid_div();
    test_no_muldiv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
